dec_timer: RTL and testbench

DEC_TIMER -- requirements
Module: dec_timer

---
 rtl/lau_pkg.sv | 6 +
 rtl/dec_timer_if.sv | 25 ++
 rtl/Dec.sv | 27 ++
 rtl/dec_timer.sv | 107 ++++++++++
 tb/tb_dec_timer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lau_pkg.sv
// rtl/lau_pkg.sv - shared option types for the lau arithmetic helpers
package lau_pkg;

  typedef enum logic {SMALL, FAST} speed_t;

endpackage

// File: rtl/dec_timer_if.sv
// rtl/dec_timer_if.sv - load handshake, control and status bundle of dec_timer
interface dec_timer_if #(
  parameter int width = 8
);

  logic             LD_VALID;
  logic             LD_READY;
  logic [width-1:0] LD_DATA;
  logic             EN;
  logic             ABORT;
  logic [width-1:0] CNT;
  logic             BUSY;
  logic             DONE;

  modport master (
    output LD_VALID, LD_DATA, EN, ABORT,
    input  LD_READY, CNT, BUSY, DONE
  );

  modport slave (
    input  LD_VALID, LD_DATA, EN, ABORT,
    output LD_READY, CNT, BUSY, DONE
  );

endinterface

// File: rtl/Dec.sv
// rtl/Dec.sv - combinational decrement by one; speed picks carry-chain or ripple form
module Dec #(
  parameter int              width = 8,
  parameter lau_pkg::speed_t speed = lau_pkg::FAST
) (
  input  logic [width-1:0] a,
  output logic [width-1:0] y
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  if (speed == lau_pkg::FAST) begin : g_fast
    assign y = a - ONE;
  end else begin : g_small
    // Explicit borrow ripple: a bit flips while every lower bit is zero.
    always_comb begin
      logic borrow;
      borrow = 1'b1;
      y      = '0;
      for (int i = 0; i < width; i++) begin
        y[i]   = a[i] ^ borrow;
        borrow = borrow & ~a[i];
      end
    end
  end

endmodule

// File: rtl/dec_timer.sv
// rtl/dec_timer.sv - loadable down-counter with one-cycle expiry pulse
// Optional auto-reload mode selected by macro DEC_TIMER_AUTORELOAD_EN.
module dec_timer #(
  parameter int              width = 8,
  parameter lau_pkg::speed_t speed = lau_pkg::FAST
) (
  input logic         CLK,
  input logic         RST,
  dec_timer_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [width-1:0] cnt_q, cnt_d, cnt_dec;
  logic             done_q, done_d;
  logic             ld_ready, ld_fire, terminal;

  Dec #(.width(width), .speed(speed)) u_dec (.a(cnt_q), .y(cnt_dec));

`ifdef DEC_TIMER_AUTORELOAD_EN
  logic [width-1:0] reload_q, reload_d, reload_val;
  assign ld_ready   = 1'b1;
  // A load landing on the terminal edge wins over the stored period.
  assign reload_val = ld_fire ? bus.LD_DATA : reload_q;
`else
  assign ld_ready = (state_q == IDLE);
`endif

  assign ld_fire  = bus.LD_VALID && ld_ready;
  assign terminal = bus.EN && (cnt_q == ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef DEC_TIMER_AUTORELOAD_EN
    reload_d = ld_fire ? bus.LD_DATA : reload_q;
`endif
    case (state_q)
      IDLE: begin
        if (ld_fire) begin
          if (bus.LD_DATA != '0) begin
            cnt_d   = bus.LD_DATA;
            state_d = RUN;
          end else begin
            cnt_d  = '0;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.ABORT) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (terminal) begin
          done_d = 1'b1;
`ifdef DEC_TIMER_AUTORELOAD_EN
          cnt_d = reload_val;
          if (reload_val == '0) begin
            state_d = IDLE;
          end
`else
          cnt_d   = '0;
          state_d = IDLE;
`endif
        end else if (bus.EN) begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef DEC_TIMER_AUTORELOAD_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign bus.LD_READY = ld_ready;
  assign bus.CNT      = cnt_q;
  assign bus.BUSY     = (state_q == RUN);
  assign bus.DONE     = done_q;

endmodule

// File: tb/tb_dec_timer.sv
// tb/tb_dec_timer.sv - vector table, corner sequences and randomized model check of dec_timer
module tb_dec_timer;

  localparam int W = 8;
`ifdef DEC_TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dec_timer_if #(.width(W)) bus ();

  dec_timer #(.width(W), .speed(lau_pkg::FAST)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         e;
    logic         a;
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
    logic         rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic e, input logic a);
    bus.LD_VALID = v;
    bus.LD_DATA  = d;
    bus.EN       = e;
    bus.ABORT    = a;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    RST = 1'b0;
  endtask

  function automatic vec_t mk(input logic v, input int d, input logic e, input logic a,
                              input int cnt, input logic busy, input logic done, input logic rdy);
    vec_t r;
    r.v = v; r.d = W'(d); r.e = e; r.a = a;
    r.cnt = W'(cnt); r.busy = busy; r.done = done; r.rdy = rdy;
    return r;
  endfunction

  task automatic build_table();
`ifndef DEC_TIMER_AUTORELOAD_EN
    vecs.push_back(mk(1, 5, 1, 0, 5, 1, 0, 0));
    for (int c = 4; c >= 1; c--) vecs.push_back(mk(0, 0, 1, 0, c, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3, 1, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 9, 0, 1, 9, 1, 0, 0));
    vecs.push_back(mk(1, 2, 1, 0, 8, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
`else
    vecs.push_back(mk(1, 2, 1, 0, 2, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2, 1, 1, 1));
    vecs.push_back(mk(1, 4, 1, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4, 1, 1, 1));
    for (int c = 3; c >= 1; c--) vecs.push_back(mk(0, 0, 1, 0, c, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4, 1, 1, 1));
    for (int c = 3; c >= 1; c--) vecs.push_back(mk(0, 0, 1, 0, c, 1, 0, 1));
    vecs.push_back(mk(1, 6, 1, 0, 6, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 6, 1, 0, 1));
    for (int c = 5; c >= 1; c--) vecs.push_back(mk(0, 0, 1, 0, c, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dones;
    int prev;
    int m_cnt, m_rel, n_cnt;
    bit m_done, accept;
    logic v, e, a;
    logic [W-1:0] d;

    RST = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #12;
    chk("reset cnt", bus.CNT, 0);
    chk("reset busy", bus.BUSY, 0);
    chk("reset done", bus.DONE, 0);
    chk("reset ready", bus.LD_READY, 1);
    tick();
    RST = 1'b0;

    build_table();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].a);
      tick();
      chk($sformatf("vec%0d cnt", i), bus.CNT, vecs[i].cnt);
      chk($sformatf("vec%0d busy", i), bus.BUSY, vecs[i].busy);
      chk($sformatf("vec%0d done", i), bus.DONE, vecs[i].done);
      chk($sformatf("vec%0d ready", i), bus.LD_READY, vecs[i].rdy);
    end

    // Abort a long count mid-way.
    do_reset();
    drive(1'b1, 8'd200, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    cyc = 0;
    while (bus.CNT != 8'd150 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("abort reach150", bus.CNT, 150);
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    chk("abort cnt", bus.CNT, 0);
    chk("abort busy", bus.BUSY, 0);
    chk("abort done", bus.DONE, 0);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    chk("abort ready", bus.LD_READY, 1);
    chk("abort nodone", bus.DONE, 0);

    // Full-scale load: 255 enabled cycles, monotonic, no wrap.
    drive(1'b1, 8'd255, 1'b1, 1'b0);
    tick();
    chk("max load cnt", bus.CNT, 255);
    drive(1'b0, '0, 1'b1, 1'b0);
    cyc = 0;
    dones = 0;
    prev = 255;
    while (bus.DONE !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
      if (bus.DONE !== 1'b1 && int'(bus.CNT) > prev) dones++;
      prev = int'(bus.CNT);
    end
    chk("max load cycles", cyc, 255);
    chk("max load wrap", dones, 0);

    // Asynchronous reset between edges mid-count.
    do_reset();
    drive(1'b1, 8'd10, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("rst pre cnt", bus.CNT, 7);
    #2;
    RST = 1'b1;
    #1;
    chk("rst async cnt", bus.CNT, 0);
    chk("rst async busy", bus.BUSY, 0);
    chk("rst async done", bus.DONE, 0);
    chk("rst async ready", bus.LD_READY, 1);
    drive(1'b1, 8'd5, 1'b1, 1'b0);
    tick();
    chk("rst no load", bus.CNT, 0);
    RST = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);
    dones = 0;
    repeat (12) begin
      tick();
      if (bus.DONE === 1'b1) dones++;
    end
    chk("rst no done", dones, 0);

    // Randomized run against a count-level model: count 0 means idle.
    do_reset();
    m_cnt  = 0;
    m_rel  = 0;
    for (int k = 0; k < 3000; k++) begin
      v = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 20));
      if ($urandom_range(0, 40) == 0) d = 8'd255;
      e = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 31) == 0);
      drive(v, d, e, a);
      #1;
      accept = v && (AR || m_cnt == 0);
      chk($sformatf("rand%0d ready", k), bus.LD_READY, (AR || m_cnt == 0));
      m_done = 1'b0;
      n_cnt  = m_cnt;
      if (m_cnt == 0) begin
        if (accept) begin
          n_cnt  = int'(d);
          m_done = (d == '0);
        end
      end else if (a) begin
        n_cnt = 0;
      end else if (e) begin
        if (m_cnt == 1) begin
          m_done = 1'b1;
          n_cnt  = AR ? (accept ? int'(d) : m_rel) : 0;
        end else begin
          n_cnt = m_cnt - 1;
        end
      end
      if (accept) m_rel = int'(d);
      m_cnt = n_cnt;
      tick();
      chk($sformatf("rand%0d cnt", k), bus.CNT, m_cnt);
      chk($sformatf("rand%0d busy", k), bus.BUSY, (m_cnt != 0));
      chk($sformatf("rand%0d done", k), bus.DONE, m_done);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
